controle_acumulador: RTL

CONTROLE_ACUMULADOR -- requirements
Module: controle_acumulador

---
 rtl/controle_acumulador.sv | 105 ++++++++++
 1 files changed

// File: rtl/controle_acumulador.sv
// Sequencer for an external accumulator: it sums Count memory words starting at BaseAddr.
// Every output comes from a flip-flop because Load and Transfer act as clocks downstream.
module controle_acumulador #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] Count,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              Load,
  output logic              Transfer,
  output logic              Clear,
  output logic              Busy,
  output logic              Done
);

  // The data path (MemData -> accumulator DataIN) bypasses this block; the width is only checked.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("DATA_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_XFER,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (Start) w_next = S_CLR;
      S_CLR:  w_next = (r_remaining != '0) ? S_READ : S_DONE;
      S_READ: w_next = S_WAIT;
      S_WAIT: w_next = S_LOAD;
      S_LOAD: w_next = S_XFER;
      S_XFER: w_next = (r_remaining == ADDR_W'(1)) ? S_DONE : S_READ;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (Abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if ((r_state == S_IDLE) && Start) begin
      r_addr      <= BaseAddr;
      r_remaining <= Count;
    end else if (r_state == S_XFER) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  // NOTE: outputs are decoded from the next state and registered, so each strobe is high
  // exactly while its state is current and never glitches.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      MemAddr  <= '0;
      MemRead  <= 1'b0;
      Load     <= 1'b0;
      Transfer <= 1'b0;
      Clear    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      MemRead  <= (w_next == S_READ);
      Load     <= (w_next == S_LOAD);
      Transfer <= (w_next == S_XFER);
      Clear    <= (w_next == S_CLR);
      Busy     <= (w_next != S_IDLE);
      Done     <= (w_next == S_DONE);
      // Leaving XFER the counter has not stepped yet, so the next address is taken one ahead.
      if (w_next == S_READ) begin
        MemAddr <= (r_state == S_XFER) ? (r_addr + ADDR_W'(1)) : r_addr;
      end
    end
  end

endmodule
